// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit header + payload stream between N_REQ requesters.
// A grant spans one whole frame; payload length is checked against the UDP length field.
module udp_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IP_TTL  = 64,
  parameter int unsigned IP_DSCP = 0
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [31:0]          local_ip,
  input  logic [N_REQ-1:0]     s_hdr_valid,
  output logic [N_REQ-1:0]     s_hdr_ready,
  input  logic [N_REQ*32-1:0]  s_dest_ip,
  input  logic [N_REQ*16-1:0]  s_src_port,
  input  logic [N_REQ*16-1:0]  s_dest_port,
  input  logic [N_REQ*16-1:0]  s_length,
  input  logic [N_REQ*8-1:0]   s_tdata,
  input  logic [N_REQ-1:0]     s_tvalid,
  output logic [N_REQ-1:0]     s_tready,
  input  logic [N_REQ-1:0]     s_tlast,
  input  logic [N_REQ-1:0]     s_tuser,
  output logic                 m_udp_hdr_valid,
  input  logic                 m_udp_hdr_ready,
  output logic [5:0]           m_udp_ip_dscp,
  output logic [1:0]           m_udp_ip_ecn,
  output logic [7:0]           m_udp_ip_ttl,
  output logic [31:0]          m_udp_ip_source_ip,
  output logic [31:0]          m_udp_ip_dest_ip,
  output logic [15:0]          m_udp_source_port,
  output logic [15:0]          m_udp_dest_port,
  output logic [15:0]          m_udp_length,
  output logic [15:0]          m_udp_checksum,
  output logic [7:0]           m_udp_payload_axis_tdata,
  output logic                 m_udp_payload_axis_tvalid,
  input  logic                 m_udp_payload_axis_tready,
  output logic                 m_udp_payload_axis_tlast,
  output logic                 m_udp_payload_axis_tuser,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_busy,
  output logic [31:0]          o_frame_cnt,
  output logic                 o_len_err
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IdxW-1:0]   gidx_q, last_q;
  logic [15:0]       len_q, cnt_q, cnt_inc;
  logic [31:0]       frame_cnt_q;
  logic              len_err_q;

  logic              found;
  logic [IdxW-1:0]   pick, j;
  logic              in_hdr, in_pay, hdr_hs, pay_hs;

  // Search starts one past the last served requester so simultaneous requests rotate.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      j = IdxW'((int'(last_q) + k) % int'(N_REQ));
      if (!found && s_hdr_valid[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  assign in_hdr = (state_q == StHdr);
  assign in_pay = (state_q == StPay);

  assign m_udp_hdr_valid    = in_hdr & s_hdr_valid[gidx_q];
  assign s_hdr_ready        = (in_hdr & m_udp_hdr_ready) ? grant_q : '0;
  assign m_udp_ip_dscp      = in_hdr ? 6'(IP_DSCP) : '0;
  assign m_udp_ip_ecn       = '0;
  assign m_udp_ip_ttl       = in_hdr ? 8'(IP_TTL) : '0;
  assign m_udp_ip_source_ip = in_hdr ? local_ip : '0;
  assign m_udp_ip_dest_ip   = in_hdr ? s_dest_ip[32*gidx_q +: 32] : '0;
  assign m_udp_source_port  = in_hdr ? s_src_port[16*gidx_q +: 16] : '0;
  assign m_udp_dest_port    = in_hdr ? s_dest_port[16*gidx_q +: 16] : '0;
  assign m_udp_length       = in_hdr ? s_length[16*gidx_q +: 16] : '0;
  assign m_udp_checksum     = '0;

  assign m_udp_payload_axis_tdata  = in_pay ? s_tdata[8*gidx_q +: 8] : '0;
  assign m_udp_payload_axis_tvalid = in_pay & s_tvalid[gidx_q];
  assign m_udp_payload_axis_tlast  = in_pay & s_tlast[gidx_q];
  assign m_udp_payload_axis_tuser  = in_pay & s_tuser[gidx_q];
  assign s_tready = (in_pay & m_udp_payload_axis_tready) ? grant_q : '0;

  assign hdr_hs  = m_udp_hdr_valid & m_udp_hdr_ready;
  assign pay_hs  = m_udp_payload_axis_tvalid & m_udp_payload_axis_tready;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign o_grant     = grant_q;
  assign o_busy      = in_hdr | in_pay;
  assign o_frame_cnt = frame_cnt_q;
  assign o_len_err   = len_err_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= IdxW'(N_REQ - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (found) begin
            gidx_q  <= pick;
            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (hdr_hs) begin
            len_q   <= s_length[16*gidx_q +: 16];
            cnt_q   <= '0;
            state_q <= StPay;
          end
        end
        StPay: begin
          if (pay_hs) begin
            cnt_q <= cnt_inc;
            if (m_udp_payload_axis_tlast) begin
              frame_cnt_q <= frame_cnt_q + 32'd1;
              last_q      <= gidx_q;
              grant_q     <= '0;
              state_q     <= StIdle;
              len_err_q   <= (len_q < 16'd8) || (cnt_inc != len_q - 16'd8);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: arbitration order, header/payload muxing, length check,
// backpressure, back-to-back grants and asynchronous reset mid-frame.
module tb_udp_tx_arbiter;
  localparam int N = 4;
  localparam logic [31:0] LocalIp = 32'h0A00_0001;

  logic          clk = 1'b0;
  logic          arst;
  logic [31:0]   local_ip;
  logic [N-1:0]  s_hdr_valid, s_hdr_ready, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [N*32-1:0] s_dest_ip;
  logic [N*16-1:0] s_src_port, s_dest_port, s_length;
  logic [N*8-1:0]  s_tdata;
  logic          m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]    m_udp_ip_dscp;
  logic [1:0]    m_udp_ip_ecn;
  logic [7:0]    m_udp_ip_ttl;
  logic [31:0]   m_udp_ip_source_ip, m_udp_ip_dest_ip;
  logic [15:0]   m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [N-1:0]  o_grant;
  logic          o_busy, o_len_err;
  logic [31:0]   o_frame_cnt;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int exp_rr[18] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1, 0, 2, 2};
  int exp_b2b[9] = '{0, 8, 8, 0, 8, 8, 0, 8, 8};

  always #5 clk = ~clk;

  udp_tx_arbiter #(.N_REQ(N), .IP_TTL(64), .IP_DSCP(0)) dut (
    .clk                       (clk),
    .arst                      (arst),
    .local_ip                  (local_ip),
    .s_hdr_valid               (s_hdr_valid),
    .s_hdr_ready               (s_hdr_ready),
    .s_dest_ip                 (s_dest_ip),
    .s_src_port                (s_src_port),
    .s_dest_port               (s_dest_port),
    .s_length                  (s_length),
    .s_tdata                   (s_tdata),
    .s_tvalid                  (s_tvalid),
    .s_tready                  (s_tready),
    .s_tlast                   (s_tlast),
    .s_tuser                   (s_tuser),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_ip_dscp             (m_udp_ip_dscp),
    .m_udp_ip_ecn              (m_udp_ip_ecn),
    .m_udp_ip_ttl              (m_udp_ip_ttl),
    .m_udp_ip_source_ip        (m_udp_ip_source_ip),
    .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (m_tdata),
    .m_udp_payload_axis_tvalid (m_tvalid),
    .m_udp_payload_axis_tready (m_tready),
    .m_udp_payload_axis_tlast  (m_tlast),
    .m_udp_payload_axis_tuser  (m_tuser),
    .o_grant                   (o_grant),
    .o_busy                    (o_busy),
    .o_frame_cnt               (o_frame_cnt),
    .o_len_err                 (o_len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame from requester r; called and returns at posedge+1 with the DUT idle.
  task automatic frame(input int r, input logic [31:0] dip, input logic [15:0] sp,
                       input logic [15:0] dp, input logic [15:0] len, input int nbytes,
                       input logic [7:0] base, input int stall, input bit tgl, input bit exp_err);
    logic [N-1:0] rbit;
    logic [3:0]   pat;
    int i, k, guard;
    rbit = 4'b0001 << r;
    pat  = 4'b1001;
    s_dest_ip[32*r +: 32]   = dip;
    s_src_port[16*r +: 16]  = sp;
    s_dest_port[16*r +: 16] = dp;
    s_length[16*r +: 16]    = len;
    s_hdr_valid[r]          = 1'b1;
    m_udp_hdr_ready         = (stall == 0);
    @(negedge clk);
    chk("arb_latency", 64'(m_udp_hdr_valid), 64'(0));
    @(posedge clk); #1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hdr_hold_valid", 64'(m_udp_hdr_valid), 64'(1));
      chk("hdr_hold_ready", 64'(s_hdr_ready), 64'(0));
      @(posedge clk); #1;
    end
    m_udp_hdr_ready = 1'b1;
    @(negedge clk);
    chk("hdr_grant", 64'(o_grant), 64'(rbit));
    chk("hdr_busy", 64'(o_busy), 64'(1));
    chk("hdr_valid", 64'(m_udp_hdr_valid), 64'(1));
    chk("hdr_ready_route", 64'(s_hdr_ready), 64'(rbit));
    chk("hdr_dest_ip", 64'(m_udp_ip_dest_ip), 64'(dip));
    chk("hdr_src_port", 64'(m_udp_source_port), 64'(sp));
    chk("hdr_dest_port", 64'(m_udp_dest_port), 64'(dp));
    chk("hdr_length", 64'(m_udp_length), 64'(len));
    chk("hdr_source_ip", 64'(m_udp_ip_source_ip), 64'(LocalIp));
    chk("hdr_ttl", 64'(m_udp_ip_ttl), 64'(64));
    chk("hdr_dscp_ecn", 64'({m_udp_ip_dscp, m_udp_ip_ecn}), 64'(0));
    chk("hdr_checksum", 64'(m_udp_checksum), 64'(0));
    @(posedge clk); #1;
    s_hdr_valid[r]      = 1'b0;
    i = 0; k = 0; guard = 0;
    s_tvalid[r]         = 1'b1;
    s_tdata[8*r +: 8]   = base;
    s_tlast[r]          = (nbytes == 1);
    while (i < nbytes && guard < 64) begin
      m_tready = (tgl && k < 4) ? pat[k] : 1'b1;
      k++; guard++;
      @(negedge clk);
      chk("pay_valid", 64'(m_tvalid), 64'(1));
      chk("pay_data", 64'(m_tdata), 64'(base + 8'(i)));
      chk("pay_last", 64'(m_tlast), 64'(i == nbytes - 1));
      chk("pay_tready", 64'(s_tready), 64'(m_tready ? rbit : 4'b0000));
      chk("pay_len_err_idle", 64'(o_len_err), 64'(0));
      if (m_tready) i++;
      @(posedge clk); #1;
      if (i < nbytes) begin
        s_tdata[8*r +: 8] = base + 8'(i);
        s_tlast[r]        = (i == nbytes - 1);
      end
    end
    chk("pay_beats", 64'(i), 64'(nbytes));
    s_tvalid[r] = 1'b0;
    s_tlast[r]  = 1'b0;
    m_tready    = 1'b1;
    exp_frames++;
    @(negedge clk);
    chk("end_grant", 64'(o_grant), 64'(0));
    chk("end_busy", 64'(o_busy), 64'(0));
    chk("end_len_err", 64'(o_len_err), 64'(exp_err));
    chk("end_frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
    @(posedge clk); #1;
    @(negedge clk);
    chk("len_err_once", 64'(o_len_err), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b0;
    local_ip = LocalIp;
    s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    s_dest_ip = '0; s_src_port = '0; s_dest_port = '0; s_length = '0; s_tdata = '0;
    m_udp_hdr_ready = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("rst_grant", 64'(o_grant), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_frame_cnt", 64'(o_frame_cnt), 64'(0));
    chk("rst_len_err", 64'(o_len_err), 64'(0));
    chk("rst_valids", 64'({m_udp_hdr_valid, m_tvalid}), 64'(0));
    chk("rst_readies", 64'({s_hdr_ready, s_tready}), 64'(0));
    chk("rst_ttl_src", 64'({m_udp_ip_ttl, m_udp_ip_source_ip}), 64'(0));

    // All requesters continuously offering 1-byte frames: strict rotation from requester 0.
    @(posedge clk); #1;
    arst = 1'b1;
    s_hdr_valid = 4'hF; s_tvalid = 4'hF; s_tlast = 4'hF;
    s_tdata = 32'h4433_2211;
    s_length = {16'd9, 16'd9, 16'd9, 16'd9};
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk("rr_grant", 64'(o_grant), 64'(exp_rr[c]));
      chk("rr_hdr_ready_iso", 64'(s_hdr_ready & ~o_grant), 64'(0));
      chk("rr_tready_iso", 64'(s_tready & ~o_grant), 64'(0));
      chk("rr_len_err", 64'(o_len_err), 64'(0));
      @(posedge clk); #1;
    end
    s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    exp_frames += 6;
    @(negedge clk);
    chk("rr_frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
    @(posedge clk); #1;

    frame(0, 32'hC0A8_010A, 16'd1234, 16'd5678, 16'd12, 4, 8'hA0, 0, 1'b0, 1'b0);
    frame(1, 32'hC0A8_0114, 16'd1111, 16'd2222, 16'd20, 5, 8'h10, 0, 1'b0, 1'b1);
    frame(3, 32'h0A0B_0C0D, 16'd4000, 16'd4001, 16'd12, 4, 8'hE0, 2, 1'b1, 1'b0);

    // Requester 3 alone, back-to-back 1-byte frames.
    s_hdr_valid[3] = 1'b1; s_tvalid[3] = 1'b1; s_tlast[3] = 1'b1;
    s_length[48 +: 16] = 16'd9; s_tdata[24 +: 8] = 8'h5A;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("b2b_grant", 64'(o_grant), 64'(exp_b2b[c]));
      chk("b2b_busy", 64'(o_busy), 64'(exp_b2b[c] != 0));
      @(posedge clk); #1;
    end
    s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0;
    exp_frames += 3;
    @(negedge clk);
    chk("b2b_frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
    @(posedge clk); #1;

    // Reset in the middle of requester 2's payload.
    s_dest_ip[64 +: 32] = 32'h0202_0202;
    s_hdr_valid[2] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_hdr_valid[2] = 1'b0;
    s_tvalid[2] = 1'b1; s_tlast[2] = 1'b0; s_tdata[16 +: 8] = 8'h77;
    @(negedge clk);
    chk("mid_pay_grant", 64'(o_grant), 64'(4));
    chk("mid_pay_valid", 64'(m_tvalid), 64'(1));
    arst = 1'b0;
    #1;
    chk("arst_grant", 64'(o_grant), 64'(0));
    chk("arst_busy", 64'(o_busy), 64'(0));
    chk("arst_pay", 64'({m_tvalid, m_tdata, m_tlast}), 64'(0));
    chk("arst_readies", 64'({s_hdr_ready, s_tready}), 64'(0));
    chk("arst_frame_cnt", 64'(o_frame_cnt), 64'(0));
    chk("arst_hdr", 64'({m_udp_hdr_valid, m_udp_ip_ttl, m_udp_ip_dest_ip}), 64'(0));
    s_tvalid = '0; s_tdata = '0;
    @(posedge clk); #1;
    arst = 1'b1;
    s_dest_ip[0 +: 32] = 32'hC0A8_0001;
    s_hdr_valid = 4'b0101;
    @(negedge clk);
    chk("post_rst_idle", 64'(o_grant), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_grant", 64'(o_grant), 64'(1));
    chk("post_rst_dest", 64'(m_udp_ip_dest_ip), 64'(32'hC0A8_0001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit input of the UDP/IP stack (s_udp_* header plus 8-bit payload AXI-Stream) between N_REQ independent requesters.
- Grants one frame at a time, round-robin. The grant is held from header handshake through the payload tlast beat.
- Fills the fixed IP fields (source IP from the CSR, TTL/DSCP/ECN from parameters).
- Checks the payload length against the UDP length field and keeps a sent-frame count.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IP_TTL, 64, value driven on m_udp_ip_ttl.
- IP_DSCP, 0, value driven on m_udp_ip_dscp; m_udp_ip_ecn is always 0.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-low
- local_ip  in  32  source IP from CSR block, sampled at header handshake
- s_hdr_valid  in  N_REQ  per-requester header valid
- s_hdr_ready  out  N_REQ  per-requester header ready
- s_dest_ip  in  N_REQ*32  per-requester destination IP, slice i = [32*i+:32]
- s_src_port  in  N_REQ*16  per-requester UDP source port
- s_dest_port  in  N_REQ*16  per-requester UDP destination port
- s_length  in  N_REQ*16  per-requester UDP length (8-byte header + payload bytes)
- s_tdata  in  N_REQ*8  per-requester payload data
- s_tvalid  in  N_REQ  per-requester payload valid
- s_tready  out  N_REQ  per-requester payload ready
- s_tlast  in  N_REQ  per-requester payload last
- s_tuser  in  N_REQ  per-requester payload error flag
- m_udp_hdr_valid  out  1  header valid to stack
- m_udp_hdr_ready  in  1  header ready from stack
- m_udp_ip_dscp  out  6  IP DSCP
- m_udp_ip_ecn  out  2  IP ECN
- m_udp_ip_ttl  out  8  IP TTL
- m_udp_ip_source_ip  out  32  IP source address
- m_udp_ip_dest_ip  out  32  IP destination address
- m_udp_source_port  out  16  UDP source port
- m_udp_dest_port  out  16  UDP destination port
- m_udp_length  out  16  UDP length
- m_udp_checksum  out  16  UDP checksum, constant 0 (stack generates it)
- m_udp_payload_axis_tdata  out  8  payload data
- m_udp_payload_axis_tvalid  out  1  payload valid
- m_udp_payload_axis_tready  in  1  payload ready
- m_udp_payload_axis_tlast  out  1  payload last
- m_udp_payload_axis_tuser  out  1  payload error flag
- o_grant  out  N_REQ  one-hot current grant, 0 when IDLE
- o_busy  out  1  high in HDR and PAY
- o_frame_cnt  out  32  count of frames completed
- o_len_err  out  1  one-cycle pulse on length mismatch

Behaviour:
- Reset (arst low, async):
  - state=IDLE; grant=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - o_frame_cnt=0; o_len_err=0.
  - All valid/ready outputs 0; m_udp_* data outputs 0.
- Reset mid-frame abandons the frame with no tlast emitted; requesters must also be reset.
- FSM IDLE:
  - If any s_hdr_valid is high, register the grant to the first set bit searching last+1, last+2, ... (mod N_REQ), then go to HDR.
  - One-cycle arbitration latency: request seen at cycle t gives m_udp_hdr_valid=1 at t+1.
- FSM HDR:
  - m_udp_hdr_valid = s_hdr_valid[g]. Header fields are muxed combinationally from slice g.
  - s_hdr_ready[g] = m_udp_hdr_ready; all other s_hdr_ready=0.
  - On handshake, latch s_length[g] into len_q, clear byte counter cnt, go to PAY.
  - If the requester drops valid, wait; there is no timeout.
- FSM PAY:
  - m_udp_payload_axis_* = slice g.
  - s_tready[g] = m_udp_payload_axis_tready; all others 0.
  - Each payload handshake does cnt+1 (16-bit, saturating at 0xFFFF).
  - On a tlast handshake:
    - o_frame_cnt+1 (wraps 0xFFFFFFFF -> 0); last=g; grant=0; return to IDLE.
    - o_len_err pulses next cycle if (cnt+1) != len_q-8, or if len_q<8.
- Re-arbitration happens only in IDLE, so each frame has at least one idle cycle between frames.
- No output handshake signal depends on any non-granted requester.
- Simultaneous requests are resolved strictly round-robin. A single active requester is granted back-to-back.
- tuser is passed through unmodified; a frame with tuser set is still counted.

Test Plan:
- Single requester 0, dest_ip 0xC0A8010A, ports 1234->5678, length 12, 4 payload bytes, stack always ready:
  - m_udp_hdr_valid rises 1 cycle after s_hdr_valid, with fields matching and source_ip=local_ip, ttl=64, checksum=0.
  - 4 bytes pass through; o_frame_cnt=1; o_len_err=0.
- All 4 requesters request continuously, each sending 1-byte frames:
  - Grant order 0,1,2,3,0,1; o_grant is one-hot during each frame.
  - Non-granted s_tready and s_hdr_ready stay 0.
- Requester 1 sends length 20 but only 5 payload bytes -> o_len_err pulses exactly once, one cycle after tlast; o_frame_cnt still increments.
- Downstream tready toggles 1,0,0,1 during payload:
  - Granted s_tready mirrors it; no data is lost or duplicated.
  - Header is held until m_udp_hdr_ready.
- arst asserted during PAY of requester 2:
  - All outputs go to 0 immediately.
  - After release, a request from requesters 0 and 2 is granted to requester 0 first.
- Requester 3 only, 3 frames back-to-back -> granted every frame, with one IDLE cycle between frames.
